apb_request_arbiter: RTL and testbench
======================================

# apb_request_arbiter

Shares the single APB master (the AXI4-to-APB bridge master with UART/TIMER select) between `NUM_REQ` independent requesters, such as the AXI write path, the AXI read path and debug/DMA ports.
- Grants one requester at a time in round-robin order.
- Latches its command and sequences the master's `transfer`/`read`/`write` controls.
- Waits for `apb_done`, then returns read data and error status to the granted requester.
- Exactly one APB transaction is outstanding at any time.

## Interface
- `ADDR_WIDTH`, 32, APB address width
- `DATA_WIDTH`, 32, APB data width
- `NUM_REQ`, 4, number of requesters (≥2)

Ports:
- `PCLK`  in  1  clock; all logic on rising edge
- `PRESET`  in  1  reset, asynchronous, active-high
- `req_valid`  in  NUM_REQ  per-requester command valid
- `req_write`  in  NUM_REQ  1 = write, 0 = read
- `req_addr`  in  NUM_REQ*ADDR_WIDTH  packed; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- `req_wdata`  in  NUM_REQ*DATA_WIDTH  packed write data
- `req_strb`  in  NUM_REQ*4  packed byte strobes
- `req_ready`  out  NUM_REQ  one-hot command accept
- `rsp_valid`  out  NUM_REQ  one-hot, one-cycle completion pulse
- `rsp_rdata`  out  DATA_WIDTH  read data, valid with `rsp_valid`
- `rsp_err`  out  1  slave error, valid with `rsp_valid`
- `transfer`  out  1  start pulse to APB master
- `read`, `write`  out  1 each  direction to APB master
- `WSTRB`  out  4  strobes to APB master
- `apb_waddr`, `apb_raddr`  out  ADDR_WIDTH  both driven with the latched address
- `apb_wdata`  out  DATA_WIDTH  latched write data
- `apb_rdata`  in  DATA_WIDTH  master read data
- `apb_done`  in  1  master completion (PSEL & PENABLE & PREADY)
- `PSLVERR`  in  1  slave error

## Operation
- **State machine:** IDLE → ISSUE → WAIT → RESP → IDLE.
- **IDLE**
  - If any `req_valid` is high, grant `g` = first set bit searching upward from `last_grant+1`, wrapping modulo NUM_REQ.
  - `req_ready[g]` is asserted combinationally in the same cycle.
  - On that edge: latch `req_write[g]`, `req_addr[g]`, `req_wdata[g]`, `req_strb[g]` and `g`; go to ISSUE.
  - No valid requests: stay in IDLE; all master outputs are 0.
- **ISSUE**
  - `transfer`=1 for exactly this one cycle; go to WAIT.
- **WAIT**
  - `transfer`=0, so the master returns to IDLE after completion and never chains into SETUP.
  - On `apb_done`=1: capture `apb_rdata` (reads only; writes load 0) and `PSLVERR` into the response registers; go to RESP.
- **RESP**
  - `rsp_valid[g]`=1 for one cycle; `last_grant` ← `g`; go to IDLE.
- **Master command outputs**, ISSUE through WAIT:
  - `write`=cmd_write, `read`=~cmd_write.
  - `WSTRB`=cmd_strb on writes, 0 on reads.
  - `apb_waddr`=`apb_raddr`=cmd_addr; the master decodes PSEL from `apb_waddr` for reads too.
  - `apb_wdata`=cmd_wdata.
  - In IDLE and RESP, `read`/`write`/`WSTRB` are 0; address and data hold their last values.
- **Response hold:** `rsp_rdata`/`rsp_err` hold until the next RESP load.
- **Requester rules**
  - Once `req_valid[i]` is high, its fields must stay stable until `req_ready[i]`.
  - A requester may drop `req_valid` before it is granted.
  - A requester must not expect `req_ready` outside IDLE.
- **Boundary conditions**
  - `apb_done` outside WAIT is ignored.
  - All requesters valid → strict rotation; no starvation (worst-case wait is NUM_REQ−1 transactions).
  - A requester that is re-valid in the IDLE cycle right after its own RESP loses to any other valid requester.
- **Reset** (any time, including mid-WAIT):
  - state = IDLE, `last_grant` = NUM_REQ−1 (requester 0 has first priority).
  - All outputs 0, response registers 0.
  - No `rsp_valid` is issued for the aborted command; the APB master must be reset by the same event.

## Timing
- Reset values: `req_ready`, `rsp_valid`, `rsp_rdata`, `rsp_err`, `transfer`, `read`, `write`, `WSTRB`, `apb_waddr`, `apb_raddr`, `apb_wdata` are all 0.
- Handshake in cycle 0 (IDLE) gives:
  - cycle 1: ISSUE, `transfer`=1
  - cycle 2: master SETUP
  - cycle 3: master ACCESS; `apb_done` if PREADY
  - cycle 4: `rsp_valid`
- Zero-wait-state latency is 4 cycles; each PREADY wait state adds 1.
- Next grant is possible at cycle 5 at the earliest. Peak throughput is one transaction per 5 cycles.
- `req_ready` and grant selection are combinational from `req_valid` and state. All other outputs are registered or decoded from state only.

## Test plan
- **Single write:** reset, then req 2 writes addr 0x0000_0010, data 0xDEADBEEF, strb 0xF; PREADY=1 → `req_ready`=4'b0100 at cycle 0, `transfer` at cycle 1, `write`=1, `WSTRB`=0xF, `apb_waddr`=0x10, `rsp_valid`=4'b0100 at cycle 4, `rsp_err`=0.
- **Read with wait states:** req 0 reads 0x1000_0004; slave inserts 2 wait states and returns 0x12345678 → `read`=1, `WSTRB`=0, `apb_raddr`=`apb_waddr`=0x1000_0004, `rsp_valid[0]` at cycle 6, `rsp_rdata`=0x12345678.
- **Full rotation:** all four `req_valid` held high from reset → grants 0,1,2,3,0 on `req_ready` cycles 0,5,10,15,20; never two `req_ready` bits set at once.
- **Round-robin order:** `last_grant`=1, then req 1 and req 3 valid together → req 3 granted first, req 1 next.
- **Slave error:** `PSLVERR`=1 in the `apb_done` cycle of a req 1 write → `rsp_err`=1 with `rsp_valid[1]`. A following clean transaction gives `rsp_err`=0.
- **Reset mid-operation:** `PRESET` pulsed during WAIT → all outputs 0 immediately (asynchronous), no `rsp_valid`. After release, simultaneous req 0 and req 3 → req 0 granted.

Source files
------------

// File: rtl/apb_request_arbiter.sv
// Round-robin arbiter that shares one APB master between NUM_REQ requesters.
// Only one APB transaction is outstanding at a time. Each one runs IDLE -> ISSUE -> WAIT -> RESP.
module apb_request_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REQ    = 4
) (
  input  logic                             PCLK,
  input  logic                             PRESET,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ-1:0]               req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
  input  logic [NUM_REQ*4-1:0]             req_strb,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic [NUM_REQ-1:0]               rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic                             rsp_err,
  output logic                             transfer,
  output logic                             read,
  output logic                             write,
  output logic [3:0]                       WSTRB,
  output logic [ADDR_WIDTH-1:0]            apb_waddr,
  output logic [ADDR_WIDTH-1:0]            apb_raddr,
  output logic [DATA_WIDTH-1:0]            apb_wdata,
  input  logic [DATA_WIDTH-1:0]            apb_rdata,
  input  logic                             apb_done,
  input  logic                             PSLVERR
);

  localparam int unsigned GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [GW-1:0]         last_grant_q;
  logic [GW-1:0]         cmd_grant_q;
  logic                  cmd_write_q;
  logic [ADDR_WIDTH-1:0] cmd_addr_q;
  logic [DATA_WIDTH-1:0] cmd_wdata_q;
  logic [3:0]            cmd_strb_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic                  rsp_err_q;

  logic                  low_found, high_found, grant_found;
  logic [GW-1:0]         low_idx, high_idx, grant_idx;
  logic                  sel_write;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [3:0]            sel_strb;
  logic                  accept, capture;

  // Rotating priority: the lowest valid index above last_grant wins, otherwise the lowest valid index overall.
  always_comb begin
    low_found  = 1'b0;
    low_idx    = '0;
    high_found = 1'b0;
    high_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        low_found = 1'b1;
        low_idx   = GW'(i);
        if (GW'(i) > last_grant_q) begin
          high_found = 1'b1;
          high_idx   = GW'(i);
        end
      end
    end
    grant_found = low_found;
    grant_idx   = high_found ? high_idx : low_idx;
  end

  // Command fields of the winning requester
  always_comb begin
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_strb  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (GW'(i) == grant_idx) begin
        sel_write = req_write[i];
        sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_strb  = req_strb[i*4 +: 4];
      end
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state, accept/capture strobes, and outputs decoded from state
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    capture   = 1'b0;
    req_ready = '0;
    rsp_valid = '0;
    transfer  = 1'b0;
    read      = 1'b0;
    write     = 1'b0;
    WSTRB     = '0;
    case (state_q)
      ST_IDLE: begin
        if (grant_found) begin
          accept               = 1'b1;
          req_ready[grant_idx] = 1'b1;
          state_d              = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        transfer = 1'b1;
        read     = ~cmd_write_q;
        write    = cmd_write_q;
        WSTRB    = cmd_write_q ? cmd_strb_q : 4'h0;
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        read  = ~cmd_write_q;
        write = cmd_write_q;
        WSTRB = cmd_write_q ? cmd_strb_q : 4'h0;
        if (apb_done) begin
          capture = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        rsp_valid[cmd_grant_q] = 1'b1;
        state_d                = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Latched command, response registers and round-robin pointer
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      last_grant_q <= GW'(NUM_REQ - 1);
      cmd_grant_q  <= '0;
      cmd_write_q  <= 1'b0;
      cmd_addr_q   <= '0;
      cmd_wdata_q  <= '0;
      cmd_strb_q   <= '0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      if (accept) begin
        cmd_grant_q <= grant_idx;
        cmd_write_q <= sel_write;
        cmd_addr_q  <= sel_addr;
        cmd_wdata_q <= sel_wdata;
        cmd_strb_q  <= sel_strb;
      end
      if (capture) begin
        rsp_rdata_q <= cmd_write_q ? '0 : apb_rdata;
        rsp_err_q   <= PSLVERR;
      end
      if (state_q == ST_RESP) last_grant_q <= cmd_grant_q;
    end
  end

  assign apb_waddr = cmd_addr_q;
  assign apb_raddr = cmd_addr_q;
  assign apb_wdata = cmd_wdata_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_request_arbiter.sv
// Directed bench for apb_request_arbiter: a per-cycle vector table plus hand-written
// sequences for full rotation and reset in the middle of a transaction.
module tb_apb_request_arbiter;

  localparam logic [31:0] A0 = 32'h1000_0004, A1 = 32'h2000_0008, A2 = 32'h0000_0010, A3 = 32'h3000_000C;
  localparam logic [31:0] D0 = 32'h0BAD_0BAD, D1 = 32'hCAFE_F00D, D2 = 32'hDEAD_BEEF, D3 = 32'h3333_3333;
  localparam logic [31:0] R1 = 32'h1234_5678, R5 = 32'hA5A5_A5A5;

  logic         PCLK = 1'b0;
  logic         PRESET;
  logic [3:0]   req_valid, req_write;
  logic [127:0] req_addr, req_wdata;
  logic [15:0]  req_strb;
  logic [3:0]   req_ready, rsp_valid;
  logic [31:0]  rsp_rdata;
  logic         rsp_err, transfer, read, write;
  logic [3:0]   WSTRB;
  logic [31:0]  apb_waddr, apb_raddr, apb_wdata, apb_rdata;
  logic         apb_done, PSLVERR;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [3:0]  valid, wr;
    logic        done;
    logic [31:0] rdata;
    logic        serr;
    logic [3:0]  e_ready;
    logic        e_tr, e_rd, e_wr;
    logic [3:0]  e_ws;
    logic [31:0] e_addr, e_wd;
    logic [3:0]  e_rv;
    logic        e_re;
    logic [31:0] e_rrd;
  } vec_t;

  vec_t vecs[29];
  logic [31:0] addr_tab[4];
  logic [31:0] data_tab[4];

  apb_request_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REQ(4)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_strb(req_strb), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .transfer(transfer), .read(read), .write(write), .WSTRB(WSTRB),
    .apb_waddr(apb_waddr), .apb_raddr(apb_raddr), .apb_wdata(apb_wdata),
    .apb_rdata(apb_rdata), .apb_done(apb_done), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  function automatic vec_t mk(input logic [3:0] valid, input logic [3:0] wr, input logic done,
                              input logic [31:0] rdata, input logic serr, input logic [3:0] e_ready,
                              input logic e_tr, input logic e_rd, input logic e_wr, input logic [3:0] e_ws,
                              input logic [31:0] e_addr, input logic [31:0] e_wd, input logic [3:0] e_rv,
                              input logic e_re, input logic [31:0] e_rrd);
    vec_t v;
    v.valid = valid; v.wr = wr; v.done = done; v.rdata = rdata; v.serr = serr;
    v.e_ready = e_ready; v.e_tr = e_tr; v.e_rd = e_rd; v.e_wr = e_wr; v.e_ws = e_ws;
    v.e_addr = e_addr; v.e_wd = e_wd; v.e_rv = e_rv; v.e_re = e_re; v.e_rrd = e_rrd;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    req_valid = v.valid;
    req_write = v.wr;
    apb_done  = v.done;
    apb_rdata = v.rdata;
    PSLVERR   = v.serr;
  endtask

  task automatic check(input string name, input vec_t v);
    vectors++;
    if (req_ready !== v.e_ready || transfer !== v.e_tr || read !== v.e_rd || write !== v.e_wr ||
        WSTRB !== v.e_ws || apb_waddr !== v.e_addr || apb_raddr !== v.e_addr || apb_wdata !== v.e_wd ||
        rsp_valid !== v.e_rv || rsp_err !== v.e_re || rsp_rdata !== v.e_rrd) begin
      miscompares++;
      $display("FAIL %s: got ready=%b tr=%b rd=%b wr=%b strb=%h waddr=%h raddr=%h wdata=%h rspv=%b err=%b rdata=%h; want ready=%b tr=%b rd=%b wr=%b strb=%h addr=%h wdata=%h rspv=%b err=%b rdata=%h",
               name, req_ready, transfer, read, write, WSTRB, apb_waddr, apb_raddr, apb_wdata,
               rsp_valid, rsp_err, rsp_rdata, v.e_ready, v.e_tr, v.e_rd, v.e_wr, v.e_ws,
               v.e_addr, v.e_wd, v.e_rv, v.e_re, v.e_rrd);
    end
  endtask

  // Inputs are driven just after a rising edge; outputs are sampled mid-cycle.
  task automatic apply(input string name, input vec_t v);
    drive(v);
    #2;
    check(name, v);
    @(posedge PCLK);
    #1;
  endtask

  initial begin
    vec_t v, z;
    int g, pg, ph;

    addr_tab = '{A0, A1, A2, A3};
    data_tab = '{D0, D1, D2, D3};
    req_addr  = {A3, A2, A1, A0};
    req_wdata = {D3, D2, D1, D0};
    req_strb  = {4'h5, 4'hF, 4'h3, 4'hF};
    z = mk(0,0,0,0,0, 0,0,0,0,0, 0,0, 0,0,0);
    drive(z);
    PRESET = 1'b1;

    // Single write from req 2, then stray apb_done in IDLE
    vecs[0]  = mk(4'b0100,4'b0100,0,0,0,            4'b0100,0,0,0,4'h0, 0,0,   4'b0000,0,0);
    vecs[1]  = mk(0,0,0,0,0,                        0,1,0,1,4'hF, A2,D2, 0,0,0);
    vecs[2]  = mk(0,0,0,0,0,                        0,0,0,1,4'hF, A2,D2, 0,0,0);
    vecs[3]  = mk(0,0,1,32'h5555_5555,0,            0,0,0,1,4'hF, A2,D2, 0,0,0);
    vecs[4]  = mk(0,0,0,0,0,                        0,0,0,0,4'h0, A2,D2, 4'b0100,0,0);
    vecs[5]  = mk(0,0,1,32'hFFFF_FFFF,1,            0,0,0,0,4'h0, A2,D2, 0,0,0);
    vecs[6]  = mk(0,0,0,0,0,                        0,0,0,0,4'h0, A2,D2, 0,0,0);
    // Read from req 0 with two wait states, stray apb_done during ISSUE
    vecs[7]  = mk(4'b0001,0,0,0,0,                  4'b0001,0,0,0,4'h0, A2,D2, 0,0,0);
    vecs[8]  = mk(0,0,1,32'hFFFF_FFFF,0,            0,1,1,0,4'h0, A0,D0, 0,0,0);
    vecs[9]  = mk(0,0,0,0,0,                        0,0,1,0,4'h0, A0,D0, 0,0,0);
    vecs[10] = mk(0,0,0,0,0,                        0,0,1,0,4'h0, A0,D0, 0,0,0);
    vecs[11] = mk(0,0,0,0,0,                        0,0,1,0,4'h0, A0,D0, 0,0,0);
    vecs[12] = mk(0,0,1,R1,0,                       0,0,1,0,4'h0, A0,D0, 0,0,0);
    vecs[13] = mk(0,0,0,0,0,                        0,0,0,0,4'h0, A0,D0, 4'b0001,0,R1);
    // Slave error on a req 1 write
    vecs[14] = mk(4'b0010,4'b0010,0,0,0,            4'b0010,0,0,0,4'h0, A0,D0, 0,0,R1);
    vecs[15] = mk(0,0,0,0,0,                        0,1,0,1,4'h3, A1,D1, 0,0,R1);
    vecs[16] = mk(0,0,0,0,0,                        0,0,0,1,4'h3, A1,D1, 0,0,R1);
    vecs[17] = mk(0,0,1,32'h5555_5555,1,            0,0,0,1,4'h3, A1,D1, 0,0,R1);
    vecs[18] = mk(0,0,0,0,0,                        0,0,0,0,4'h0, A1,D1, 4'b0010,1,0);
    // last_grant=1: req 1 and req 3 together -> 3 first, then 1; error clears
    vecs[19] = mk(4'b1010,4'b0010,0,0,0,            4'b1000,0,0,0,4'h0, A1,D1, 0,1,0);
    vecs[20] = mk(4'b0010,4'b0010,0,0,0,            0,1,1,0,4'h0, A3,D3, 0,1,0);
    vecs[21] = mk(4'b0010,4'b0010,0,0,0,            0,0,1,0,4'h0, A3,D3, 0,1,0);
    vecs[22] = mk(4'b0010,4'b0010,1,R5,0,           0,0,1,0,4'h0, A3,D3, 0,1,0);
    vecs[23] = mk(4'b0010,4'b0010,0,0,0,            0,0,0,0,4'h0, A3,D3, 4'b1000,0,R5);
    vecs[24] = mk(4'b0010,4'b0010,0,0,0,            4'b0010,0,0,0,4'h0, A3,D3, 0,0,R5);
    vecs[25] = mk(0,0,0,0,0,                        0,1,0,1,4'h3, A1,D1, 0,0,R5);
    vecs[26] = mk(0,0,1,32'h7777_7777,0,            0,0,0,1,4'h3, A1,D1, 0,0,R5);
    vecs[27] = mk(0,0,0,0,0,                        0,0,0,0,4'h0, A1,D1, 4'b0010,0,0);
    vecs[28] = mk(0,0,0,0,0,                        0,0,0,0,4'h0, A1,D1, 0,0,0);

    repeat (2) @(posedge PCLK);
    #1;
    check("reset_values", z);
    PRESET = 1'b0;

    for (int i = 0; i < 29; i++) apply($sformatf("vec%0d", i), vecs[i]);

    // Full rotation with all four requesters valid from reset
    drive(mk(4'hF,0,0,0,0, 0,0,0,0,0, 0,0, 0,0,0));
    PRESET = 1'b1;
    @(posedge PCLK);
    #1;
    PRESET = 1'b0;
    for (int c = 0; c < 25; c++) begin
      g  = (c / 5) % 4;
      pg = (g + 3) % 4;
      ph = c % 5;
      v = mk(4'hF, 4'h0, ph == 3, 32'h100 + 32'(g), 0,
             (ph == 0) ? 4'(1 << g) : 4'h0, ph == 1, (ph >= 1 && ph <= 3), 0, 4'h0,
             (ph != 0) ? addr_tab[g] : ((c == 0) ? 32'h0 : addr_tab[pg]),
             (ph != 0) ? data_tab[g] : ((c == 0) ? 32'h0 : data_tab[pg]),
             (ph == 4) ? 4'(1 << g) : 4'h0, 0,
             (ph == 4) ? 32'h100 + 32'(g) : ((c < 5) ? 32'h0 : 32'h100 + 32'(pg)));
      apply($sformatf("rotation_c%0d", c), v);
    end

    // Reset asserted during WAIT of a req 1 write
    apply("mid_grant",  mk(4'b0010,4'b0010,0,0,0, 4'b0010,0,0,0,4'h0, A0,D0, 0,0,32'h100));
    apply("mid_issue",  mk(0,0,0,0,0,             0,1,0,1,4'h3, A1,D1, 0,0,32'h100));
    apply("mid_wait",   mk(0,0,0,0,0,             0,0,0,1,4'h3, A1,D1, 0,0,32'h100));
    drive(mk(0,0,1,32'h9999_9999,1, 0,0,0,0,0, 0,0, 0,0,0));
    #1;
    PRESET = 1'b1;
    #1;
    check("async_reset", z);
    @(posedge PCLK);
    #1;
    PRESET = 1'b0;
    apply("post_reset_idle", z);
    apply("post_reset_quiet", z);
    apply("post_reset_grant", mk(4'b1001,0,0,0,0, 4'b0001,0,0,0,4'h0, 0,0, 0,0,0));
    apply("post_reset_issue", mk(0,0,0,0,0,       0,1,1,0,4'h0, A0,D0, 0,0,0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
